// File: rtl/spi_frame_reader_pkg.sv
// Shared definitions for the SPI frame reader: command opcodes, FSM states
// and the status byte layout returned to the MCU.
package spi_frame_pkg;

    localparam int FRAME_BYTES_DEFAULT = 9600;

    localparam logic [7:0] CMD_STATUS     = 8'h01;
    localparam logic [7:0] CMD_READ_FRAME = 8'h02;
    localparam logic [7:0] CMD_ACK        = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        STAT,
        FRAME,
        DRAIN
    } state_t;

    function automatic logic [7:0] status_byte(input logic overrun, input logic ready);
        return {6'b000000, overrun, ready};
    endfunction

endpackage

// File: rtl/spi_frame_reader_if.sv
// Bundle of SPI pins and ping-pong buffer read port seen by the frame reader.
// The slave modport is the reader's view; master is the MCU/buffer side.
interface spi_frame_reader_if;

    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [16:0] spi_rd_addr;
    logic [7:0]  spi_rd_data;
    logic        buffer_ready;
    logic        frame_read_complete;

    modport slave (
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        input  spi_rd_data,
        input  buffer_ready,
        output spi_miso,
        output spi_rd_addr,
        output frame_read_complete
    );

    modport master (
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        output spi_rd_data,
        output buffer_ready,
        input  spi_miso,
        input  spi_rd_addr,
        input  frame_read_complete
    );

endinterface

// File: rtl/spi_frame_reader_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, with single-cycle
// rise/fall strobes derived from the synchronized level.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic sys_clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   prev_reg;

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            sync_reg <= {SYNC_STAGES{RESET_VAL}};
            prev_reg <= RESET_VAL;
        end else begin
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                sync_reg[i] <= sync_reg[i-1];
            end
            sync_reg[0] <= pin;
            prev_reg    <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign level = sync_reg[SYNC_STAGES-1];
    assign rise  = level & ~prev_reg;
    assign fall  = ~level & prev_reg;

endmodule

// File: rtl/spi_frame_reader.sv
// SPI mode-0 slave, oversampled by sys_clk, that reports frame status and
// streams the packed frame out of the ping-pong buffer with one-byte prefetch.
module spi_frame_reader
    import spi_frame_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEFAULT,
    parameter int RD_LATENCY  = 2,
    parameter int SYNC_STAGES = 2
) (
    input logic               sys_clk,
    input logic               reset,
    spi_frame_reader_if.slave bus
);

    localparam logic [13:0] LAST_IDX = 14'(FRAME_BYTES - 1);
    // Pin order is {mosi, cs_n, sclk}; cs_n idles high so reset does not fake a select.
    localparam logic [2:0]  PIN_IDLE = 3'b010;

    logic [2:0] pin_raw;
    logic [2:0] pin_level;
    logic [2:0] pin_rise;
    logic [2:0] pin_fall;

    assign pin_raw = {bus.spi_mosi, bus.spi_cs_n, bus.spi_sclk};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_pin
            spi_pin_sync #(
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_VAL   (PIN_IDLE[gi])
            ) u_sync (
                .sys_clk (sys_clk),
                .reset   (reset),
                .pin     (pin_raw[gi]),
                .level   (pin_level[gi]),
                .rise    (pin_rise[gi]),
                .fall    (pin_fall[gi])
            );
        end
    endgenerate

    logic sclk_rise;
    logic sclk_fall;
    logic cs_level;
    logic cs_rise;
    logic cs_fall;
    logic mosi_level;
    logic unused_pins;

    assign sclk_rise   = pin_rise[0];
    assign sclk_fall   = pin_fall[0];
    assign cs_level    = pin_level[1];
    assign cs_rise     = pin_rise[1];
    assign cs_fall     = pin_fall[1];
    assign mosi_level  = pin_level[2];
    assign unused_pins = ^{pin_level[0], pin_rise[2], pin_fall[2]};

    state_t              state_reg,         state_next;
    logic [2:0]          bit_cnt_reg,       bit_cnt_next;
    logic [6:0]          shift_in_reg,      shift_in_next;
    logic [7:0]          shift_out_reg,     shift_out_next;
    logic [13:0]         byte_idx_reg,      byte_idx_next;
    logic [16:0]         rd_addr_reg,       rd_addr_next;
    logic [7:0]          prefetch_reg,      prefetch_next;
    logic [RD_LATENCY:0] fetch_pipe_reg,    fetch_pipe_next;
    logic                first_pending_reg, first_pending_next;
    logic                overrun_reg,       overrun_next;
    logic                frc_reg,           frc_next;

    logic [7:0] opcode;
    logic       byte_done;

    assign opcode    = {shift_in_reg, mosi_level};
    assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_reg         <= IDLE;
            bit_cnt_reg       <= '0;
            shift_in_reg      <= '0;
            shift_out_reg     <= '0;
            byte_idx_reg      <= '0;
            rd_addr_reg       <= '0;
            prefetch_reg      <= '0;
            fetch_pipe_reg    <= '0;
            first_pending_reg <= 1'b0;
            overrun_reg       <= 1'b0;
            frc_reg           <= 1'b0;
        end else begin
            state_reg         <= state_next;
            bit_cnt_reg       <= bit_cnt_next;
            shift_in_reg      <= shift_in_next;
            shift_out_reg     <= shift_out_next;
            byte_idx_reg      <= byte_idx_next;
            rd_addr_reg       <= rd_addr_next;
            prefetch_reg      <= prefetch_next;
            fetch_pipe_reg    <= fetch_pipe_next;
            first_pending_reg <= first_pending_next;
            overrun_reg       <= overrun_next;
            frc_reg           <= frc_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        bit_cnt_next       = bit_cnt_reg;
        shift_in_next      = shift_in_reg;
        shift_out_next     = shift_out_reg;
        byte_idx_next      = byte_idx_reg;
        rd_addr_next       = rd_addr_reg;
        prefetch_next      = prefetch_reg;
        fetch_pipe_next    = {fetch_pipe_reg[RD_LATENCY-1:0], 1'b0};
        first_pending_next = first_pending_reg;
        overrun_next       = overrun_reg;
        frc_next           = 1'b0;

        // Read data lands RD_LATENCY cycles after the address moved; byte 0 goes
        // straight to the shifter, every later byte waits in the prefetch register.
        if (fetch_pipe_reg[RD_LATENCY]) begin
            if (first_pending_reg) begin
                shift_out_next     = bus.spi_rd_data;
                first_pending_next = 1'b0;
                if (LAST_IDX != 14'd0) begin
                    rd_addr_next       = {14'd1, 3'b000};
                    fetch_pipe_next[0] = 1'b1;
                end
            end else begin
                prefetch_next = bus.spi_rd_data;
            end
        end

        if (cs_level) begin
            state_next         = IDLE;
            bit_cnt_next       = '0;
            shift_out_next     = '0;
            fetch_pipe_next    = '0;
            first_pending_next = 1'b0;
            // A final byte that completes in the deselect cycle still releases the buffer.
            if (cs_rise && state_reg == FRAME && byte_done &&
                byte_idx_reg == LAST_IDX && !first_pending_reg) begin
                frc_next = 1'b1;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cs_fall) begin
                        state_next     = CMD;
                        bit_cnt_next   = '0;
                        shift_out_next = '0;
                    end
                end

                CMD: begin
                    if (sclk_rise) begin
                        shift_in_next = opcode[6:0];
                        bit_cnt_next  = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            case (opcode)
                                CMD_STATUS: begin
                                    state_next     = STAT;
                                    shift_out_next = status_byte(overrun_reg, bus.buffer_ready);
                                end
                                CMD_READ_FRAME: begin
                                    if (bus.buffer_ready) begin
                                        state_next         = FRAME;
                                        byte_idx_next      = '0;
                                        rd_addr_next       = '0;
                                        fetch_pipe_next    = '0;
                                        fetch_pipe_next[0] = 1'b1;
                                        first_pending_next = 1'b1;
                                    end else begin
                                        overrun_next = 1'b1;
                                        state_next   = DRAIN;
                                    end
                                end
                                CMD_ACK: begin
                                    frc_next   = 1'b1;
                                    state_next = DRAIN;
                                end
                                default: begin
                                    state_next = DRAIN;
                                end
                            endcase
                        end
                    end
                end

                STAT: begin
                    // The fall right after a byte boundary keeps bit 7 on the line.
                    if (sclk_fall && bit_cnt_reg != 3'd0) begin
                        shift_out_next = {shift_out_reg[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            overrun_next   = 1'b0;
                            state_next     = DRAIN;
                            shift_out_next = '0;
                        end
                    end
                end

                FRAME: begin
                    if (sclk_fall && bit_cnt_reg != 3'd0) begin
                        shift_out_next = {shift_out_reg[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        bit_cnt_next = bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            if (byte_idx_reg == LAST_IDX) begin
                                frc_next        = 1'b1;
                                state_next      = DRAIN;
                                shift_out_next  = '0;
                                fetch_pipe_next = '0;
                            end else begin
                                shift_out_next = prefetch_reg;
                                byte_idx_next  = byte_idx_reg + 14'd1;
                                // Fetch the byte after the one just loaded, if the frame has one.
                                if (byte_idx_reg + 14'd1 < LAST_IDX) begin
                                    rd_addr_next       = {byte_idx_reg + 14'd2, 3'b000};
                                    fetch_pipe_next[0] = 1'b1;
                                end
                            end
                        end
                    end
                end

                DRAIN: begin
                    shift_out_next = '0;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.spi_miso            = shift_out_reg[7];
    assign bus.spi_rd_addr         = rd_addr_reg;
    assign bus.frame_read_complete = frc_reg;

endmodule

// File: tb/tb_spi_frame_reader.sv
// Directed-plus-random bench: an MCU-side SPI master and a 2-cycle-latency
// buffer drive the reader; expected bytes and pulses come from a command-level model.
module tb_spi_frame_reader;
    import spi_frame_pkg::*;

    localparam int N = 300;

    logic sys_clk = 1'b0;
    logic reset;

    always #5 sys_clk = ~sys_clk;

    spi_frame_reader_if bus();

    spi_frame_reader #(
        .FRAME_BYTES (N),
        .RD_LATENCY  (2),
        .SYNC_STAGES (2)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Buffer contents and the MCU-visible overrun flag held by the model.
    logic [7:0] mem [N];
    logic       ov_m = 1'b0;

    function automatic logic [7:0] mem_at(input logic [16:0] addr);
        int idx;
        idx = int'(addr >> 3);
        if (idx < N) return mem[idx];
        return 8'h00;
    endfunction

    logic [7:0] rd_pipe;
    always @(posedge sys_clk) begin
        rd_pipe         <= mem_at(bus.spi_rd_addr);
        bus.spi_rd_data <= rd_pipe;
    end

    int frc_cycles = 0;
    always @(posedge sys_clk) begin
        if (bus.frame_read_complete === 1'b1) frc_cycles <= frc_cycles + 1;
    end

    logic [16:0] addr_log [$];
    logic [16:0] last_addr = '0;
    always @(posedge sys_clk) begin
        if (bus.spi_rd_addr !== last_addr) addr_log.push_back(bus.spi_rd_addr);
        last_addr <= bus.spi_rd_addr;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One mode-0 byte: MOSI changes with SCLK low, MISO sampled at the rising edge.
    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int b = 7; b >= 0; b--) begin
            bus.spi_mosi = tx[b];
            tick(4);
            rx[b] = bus.spi_miso;
            bus.spi_sclk = 1'b1;
            tick(4);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic transaction(input logic [7:0] op, input int ndata, input logic rdy);
        int         frc0;
        int         exp_pulses;
        logic [7:0] rx;
        logic [7:0] exp;
        logic [7:0] st;
        logic       streaming;

        bus.buffer_ready = rdy;
        tick(2);
        frc0       = frc_cycles;
        exp_pulses = 0;
        st         = {6'b0, ov_m, rdy};
        streaming  = (op == CMD_READ_FRAME) && rdy;
        if (op == CMD_READ_FRAME && !rdy) ov_m = 1'b1;
        if (op == CMD_ACK) exp_pulses = 1;
        if (streaming && ndata >= N) exp_pulses = 1;

        bus.spi_cs_n = 1'b0;
        tick(4);
        xfer(op, rx);
        check($sformatf("op%02h_opcode_miso", op), 32'(rx), 32'h0);
        for (int k = 0; k < ndata; k++) begin
            xfer(8'($urandom), rx);
            exp = 8'h00;
            if (op == CMD_STATUS && k == 0) exp = st;
            if (streaming && k < N) exp = mem[k];
            check($sformatf("op%02h_byte%0d", op, k), 32'(rx), 32'(exp));
            if (streaming && k == N - 2) begin
                tick(2);
                check("frc_before_last_byte", 32'(frc_cycles - frc0), 32'd0);
            end
            if (streaming && k == N - 1) begin
                tick(2);
                check("frc_at_last_byte", 32'(frc_cycles - frc0), 32'd1);
            end
        end
        if (op == CMD_STATUS && ndata >= 1) ov_m = 1'b0;
        tick(4);
        bus.spi_cs_n = 1'b1;
        tick(8);
        check($sformatf("op%02h_frc_cycles", op), 32'(frc_cycles - frc0), 32'(exp_pulses));
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] op;
        int         pick;

        reset            = 1'b1;
        bus.spi_cs_n     = 1'b1;
        bus.spi_sclk     = 1'b0;
        bus.spi_mosi     = 1'b0;
        bus.buffer_ready = 1'b1;
        for (int i = 0; i < N; i++) mem[i] = 8'(i);
        tick(5);
        check("reset_miso", 32'(bus.spi_miso), 32'h0);
        check("reset_rd_addr", 32'(bus.spi_rd_addr), 32'h0);
        check("reset_frc", 32'(bus.frame_read_complete), 32'h0);
        reset = 1'b0;
        tick(4);

        // Status polling and the sticky overrun flag.
        transaction(CMD_STATUS, 2, 1'b1);
        transaction(CMD_READ_FRAME, 3, 1'b0);
        transaction(CMD_STATUS, 1, 1'b1);
        transaction(CMD_STATUS, 1, 1'b1);
        transaction(CMD_READ_FRAME, 2, 1'b0);
        transaction(CMD_STATUS, 1, 1'b0);

        transaction(CMD_ACK, 3, 1'b1);

        // Whole frame plus one trailing byte past the end.
        transaction(CMD_READ_FRAME, N + 1, 1'b1);

        // Abort mid-frame, then a fresh read over new buffer contents.
        transaction(CMD_READ_FRAME, 100, 1'b1);
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        addr_log.delete();
        transaction(CMD_READ_FRAME, 6, 1'b1);
        check("restart_addr_logged", 32'(addr_log.size() != 0), 32'd1);
        if (addr_log.size() != 0) check("restart_first_addr", 32'(addr_log[0]), 32'h0);

        for (int it = 0; it < 8; it++) begin
            pick = int'($urandom_range(0, 3));
            op   = (pick == 0) ? 8'($urandom_range(4, 255)) : 8'(pick);
            transaction(op, int'($urandom_range(1, 3)), 1'($urandom));
        end

        // Reset while streaming byte 50.
        bus.buffer_ready = 1'b1;
        bus.spi_cs_n     = 1'b0;
        tick(4);
        xfer(CMD_READ_FRAME, rx);
        for (int k = 0; k < 50; k++) begin
            xfer(8'($urandom), rx);
            check($sformatf("pre_reset_byte%0d", k), 32'(rx), 32'(mem[k]));
        end
        tick(2);
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        ov_m  = 1'b0;
        tick(1);
        check("midreset_miso", 32'(bus.spi_miso), 32'h0);
        check("midreset_rd_addr", 32'(bus.spi_rd_addr), 32'h0);
        check("midreset_frc", 32'(bus.frame_read_complete), 32'h0);
        bus.spi_cs_n = 1'b1;
        tick(8);
        transaction(CMD_STATUS, 2, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_frame_reader.md
Name: spi_frame_reader

Overview:
- SPI slave in the sys_clk domain that lets the MCU poll frame status and stream the packed 1-bit frame out of the ping-pong SPRAM buffer.
- Sits directly downstream of the ping-pong buffer: drives its byte read address, consumes its read data and buffer_ready, and returns frame_read_complete.
- The SPI pins (SPI mode 0, MSB first) are oversampled by sys_clk; no logic is clocked by SCLK.

Parameters:
- FRAME_BYTES, 9600, bytes per frame (320x240 pixels / 8).
- RD_LATENCY, 2, sys_clk cycles from spi_rd_addr change to valid spi_rd_data.
- SYNC_STAGES, 2, synchronizer depth for the SPI pins.

Ports:
- sys_clk  in  1  system clock, 48 MHz.
- reset  in  1  synchronous, active-high reset.
- spi_sclk  in  1  SPI clock from MCU; maximum sys_clk/8.
- spi_cs_n  in  1  chip select, active low.
- spi_mosi  in  1  MCU to FPGA data.
- spi_miso  out  1  FPGA to MCU data.
- spi_rd_addr  out  17  byte_index*8 (pixel index of the byte's first pixel), 0..76792.
- spi_rd_data  in  8  packed byte from the buffer.
- buffer_ready  in  1  a full frame is available.
- frame_read_complete  out  1  one-cycle pulse releasing the buffer.

Behaviour:
- Single clock sys_clk; synchronous active-high reset.
- Reset values: spi_miso=0, spi_rd_addr=0, frame_read_complete=0, state=IDLE, overrun=0.
- Input sampling: sclk, cs_n and mosi each pass through SYNC_STAGES flops plus an edge detect.
  - All actions occur on detected edges.
  - mosi is sampled on a detected SCLK rise.
  - The MISO shift register advances on a detected SCLK fall.
- Synchronized cs_n high forces IDLE from any state, clears the bit counter and sets spi_miso=0.
  - An SCLK edge arriving in the same cycle as the CS rise is ignored.
- States:
  - IDLE: on cs_n fall go to CMD and load the shift register with 0x00.
  - CMD: shift in 8 bits. On the 8th rise, decode the opcode:
    - 0x01 STATUS: go to STAT; the next byte is {6'b0, overrun, buffer_ready} sampled at decode.
    - 0x02 READ_FRAME:
      - If buffer_ready=1: go to FRAME, byte_idx=0, spi_rd_addr=0.
      - If buffer_ready=0: set overrun=1 and go to DRAIN.
    - 0x03 ACK: pulse frame_read_complete on the next cycle, then go to DRAIN.
    - Any other opcode: go to DRAIN.
  - STAT: shift out the status byte; after it completes, go to DRAIN.
  - FRAME: stream bytes 0..FRAME_BYTES-1.
    - A prefetch register holds the next byte.
    - Each byte boundary (8th rise) loads the shift register from prefetch, increments byte_idx and drives spi_rd_addr=(byte_idx+1)*8.
    - The prefetch register captures spi_rd_data RD_LATENCY cycles after each address change.
    - First byte: fetched at opcode decode. It must be captured before the first falling edge; budget is 4 cycles at sclk ≤ sys_clk/8.
    - At the 8th rise of byte FRAME_BYTES-1: pulse frame_read_complete for exactly 1 cycle and go to DRAIN.
  - DRAIN: MISO outputs 0x00 until cs_n rises.
- MISO: bit 7 of the loaded byte is presented before the first rise; subsequent bits change on falls.
- CS aborts mid-frame: no completion pulse; the next READ_FRAME restarts at byte 0.
- overrun is sticky; it is cleared when a STATUS read completes.
- Simultaneous final-byte completion and cs_n rise in the same cycle: the completion pulse still fires.
- Reset mid-transaction: immediate IDLE; the MCU must drop CS before issuing a new command.
- byte_idx is 14 bits and never exceeds FRAME_BYTES-1. spi_rd_addr = {byte_idx, 3'b000}.

Decomposition:
- Package spi_frame_pkg:
  - opcode constants CMD_STATUS=8'h01, CMD_READ_FRAME=8'h02, CMD_ACK=8'h03;
  - state enum {IDLE, CMD, STAT, FRAME, DRAIN};
  - FRAME_BYTES default.
- Sub-module spi_pin_sync: SYNC_STAGES synchronizer plus rise/fall detect; instantiated three times (sclk, cs_n, mosi).

Test Plan:
- STATUS: buffer_ready=1 → MCU sends 0x01 then 0x00; MISO returns 0x01. With overrun set, returns 0x03, and the next STATUS returns 0x01.
- Full frame:
  - Setup: buffer model returns byte_idx[7:0] with 2-cycle latency; sclk = sys_clk/8.
  - Stimulus: 0x02 followed by 9600 bytes.
  - Response: MISO bytes 0x00,0x01,…,0xFF,0x00… match.
  - frame_read_complete pulses once, at the 8th rise of byte 9599.
  - Byte 9601 reads 0x00.
- Abort: CS rises after byte 100 → no pulse. A new 0x02 restarts at byte 0 with spi_rd_addr=0.
- ACK: 0x03 → exactly one frame_read_complete pulse; MISO stays 0x00.
- Not ready: buffer_ready=0, 0x02 → MISO all 0x00, no pulse, and the following STATUS returns 0x02.
- Reset mid-FRAME at byte 50:
  - Outputs return to reset values.
  - After CS toggles, 0x01 works normally.
